// File: rtl/dog_pkg.sv
// Shared definitions for the DoG scale-space extremum detector:
// MODE encodings, FSM state type and the widened signed compare helper.
package dog_pkg;

  // Polarity selection encodings for the MODE parameter.
  localparam int MODE_MIN  = 0;
  localparam int MODE_MAX  = 1;
  localparam int MODE_BOTH = 2;

  // Frame-tracking states.
  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } dog_state_e;

  // Compare width; operands are sign-extended into it, so DW may be up to 32.
  localparam int DOG_CMP_W = 33;

  // Strict signed greater-than. Both operands are sign-extended beforehand,
  // so (a - b) can never overflow and the result is exact.
  function automatic logic dog_sgt(input logic signed [DOG_CMP_W-1:0] a,
                                   input logic signed [DOG_CMP_W-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/dog_linebuf.sv
// One DoG plane: two line buffers (rows y-1 and y-2) feeding a 3x3 window.
// Window rows: [0] = y-2, [1] = y-1, [2] = y. Columns: [0] = x-2 .. [2] = x.
module dog_linebuf
  import dog_pkg::*;
#(
  parameter int DW    = 16,
  parameter int IMG_W = 320,
  parameter int XW    = $clog2(IMG_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic [XW-1:0]            x_i,
  input  logic [DW-1:0]            din_i,
  output logic [2:0][2:0][DW-1:0]  win_o
);

  logic [DW-1:0] line1_mem [IMG_W];
  logic [DW-1:0] line2_mem [IMG_W];

  logic [DW-1:0]           rd1;
  logic [DW-1:0]           rd2;
  logic [2:0][2:0][DW-1:0] win_d;
  logic [2:0][2:0][DW-1:0] win_q;

  // Reads see the contents before this beat's write (old data on collision).
  assign rd1 = line1_mem[x_i];
  assign rd2 = line2_mem[x_i];

  // Line storage: the new sample enters row y-1, the old row y-1 ages into row y-2.
  // NOTE: the line memories have no reset; their stale contents only reach
  // results that the x/y gating in the top already discards.
  always_ff @(posedge clk) begin
    if (en_i) begin
      line1_mem[x_i] <= din_i;
      line2_mem[x_i] <= rd1;
    end
  end

  // Window next state: shift one column left and load the new column on a beat.
  // NOTE: every always_comb target is given a default first so no latch is inferred.
  always_comb begin
    win_d = win_q;
    if (en_i) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = rd2;
      win_d[1][2] = rd1;
      win_d[2][2] = din_i;
    end
  end

  // Window register.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) win_q <= '0;
    else        win_q <= win_d;
  end

  assign win_o = win_q;

endmodule

// File: rtl/dog_extrema_stream.sv
// Streaming 3x3x3 scale-space extremum detector. Three DoG planes arrive in
// raster order, one pixel per beat; every interior centre of the middle plane
// is tested against its 26 neighbours, two cycles after the beat that
// completes its window.
// Optional build macro DOG_KPCOUNT_EN adds a per-frame keypoint counter port.
module dog_extrema_stream
  import dog_pkg::*;
#(
  parameter int DW     = 16,
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 480,
  parameter int MODE   = 2,
  parameter int THRESH = 0,
  parameter int XW     = $clog2(IMG_W),
  parameter int YW     = $clog2(IMG_H)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] dog0,
  input  logic signed [DW-1:0] dog1,
  input  logic signed [DW-1:0] dog2,
  output logic                 out_valid,
  output logic                 out_kp,
  output logic                 out_pol,
  output logic [XW-1:0]        out_x,
  output logic [YW-1:0]        out_y,
  output logic                 out_eof,
  output logic                 frame_done
`ifdef DOG_KPCOUNT_EN
  ,
  output logic [YW+XW-1:0]     kp_count
`endif
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic signed [DOG_CMP_W-1:0] THR_POS = DOG_CMP_W'(THRESH);
  localparam logic signed [DOG_CMP_W-1:0] THR_NEG = -THR_POS;
  localparam bit MAX_EN = (MODE != MODE_MIN);
  localparam bit MIN_EN = (MODE != MODE_MAX);

  // Position of neighbour (p,r,c) in the 26-bit compare vectors (centre skipped).
  function automatic int nb_idx(input int p, input int r, input int c);
    int n;
    n = p * 9 + r * 3 + c;
    return (n > 13) ? n - 1 : n;
  endfunction

  dog_state_e    state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          sof_beat;
  logic          beat;
  logic [XW-1:0] bx;
  logic [YW-1:0] by;

  // Beat acceptance: a start-of-frame beat is always (0,0), even mid-frame.
  always_comb begin
    sof_beat = in_valid && in_sof && (state_q != DONE);
    beat     = sof_beat || (in_valid && (state_q == ACTIVE));
    bx       = sof_beat ? '0 : x_q;
    by       = sof_beat ? '0 : y_q;
  end

  // Frame FSM and raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      case (state_q)
        IDLE, ACTIVE: begin
          if (beat) begin
            if (bx == X_LAST) begin
              x_q <= '0;
              if (by == Y_LAST) begin
                y_q     <= '0;
                state_q <= DONE;
              end else begin
                y_q     <= by + YW'(1);
                state_q <= ACTIVE;
              end
            end else begin
              x_q     <= bx + XW'(1);
              y_q     <= by;
              state_q <= ACTIVE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [2:0][2:0][DW-1:0]       win0;
  logic [2:0][2:0][DW-1:0]       win1;
  logic [2:0][2:0][DW-1:0]       win2;
  logic [2:0][2:0][2:0][DW-1:0]  cube;

  dog_linebuf #(.DW(DW), .IMG_W(IMG_W), .XW(XW)) u_lb0 (
    .clk(clk), .rst_n(rst_n), .en_i(beat), .x_i(bx), .din_i(dog0), .win_o(win0));
  dog_linebuf #(.DW(DW), .IMG_W(IMG_W), .XW(XW)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .en_i(beat), .x_i(bx), .din_i(dog1), .win_o(win1));
  dog_linebuf #(.DW(DW), .IMG_W(IMG_W), .XW(XW)) u_lb2 (
    .clk(clk), .rst_n(rst_n), .en_i(beat), .x_i(bx), .din_i(dog2), .win_o(win2));

  assign cube = {win2, win1, win0};

  logic          s0_valid_q;
  logic          s0_eof_q;
  logic [XW-1:0] s0_x_q;
  logic [YW-1:0] s0_y_q;

  // Stage 0: tag the window just loaded with its centre coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_eof_q   <= 1'b0;
      s0_x_q     <= '0;
      s0_y_q     <= '0;
    end else begin
      s0_valid_q <= beat && (bx >= XW'(2)) && (by >= YW'(2));
      s0_eof_q   <= beat && (bx == X_LAST) && (by == Y_LAST);
      s0_x_q     <= bx - XW'(1);
      s0_y_q     <= by - YW'(1);
    end
  end

  logic signed [DOG_CMP_W-1:0] c_e;
  logic [25:0]                 gt_d;
  logic [25:0]                 lt_d;
  logic                        hi_d;
  logic                        lo_d;

  // Compare tree: centre of the middle plane against all 26 neighbours and the threshold.
  always_comb begin
    gt_d = '0;
    lt_d = '0;
    c_e  = DOG_CMP_W'($signed(win1[1][1]));
    for (int p = 0; p < 3; p++) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          if (!(p == 1 && r == 1 && c == 1)) begin
            gt_d[5'(nb_idx(p, r, c))] = dog_sgt(c_e, DOG_CMP_W'($signed(cube[p][r][c])));
            lt_d[5'(nb_idx(p, r, c))] = dog_sgt(DOG_CMP_W'($signed(cube[p][r][c])), c_e);
          end
        end
      end
    end
    hi_d = dog_sgt(c_e, THR_POS);
    lo_d = dog_sgt(THR_NEG, c_e);
  end

  logic          s1_valid_q;
  logic          s1_eof_q;
  logic [XW-1:0] s1_x_q;
  logic [YW-1:0] s1_y_q;
  logic [25:0]   gt_q;
  logic [25:0]   lt_q;
  logic          hi_q;
  logic          lo_q;

  // Stage 1: register the compare results alongside the control tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_eof_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      gt_q       <= '0;
      lt_q       <= '0;
      hi_q       <= 1'b0;
      lo_q       <= 1'b0;
    end else begin
      s1_valid_q <= s0_valid_q;
      s1_eof_q   <= s0_eof_q;
      s1_x_q     <= s0_x_q;
      s1_y_q     <= s0_y_q;
      gt_q       <= gt_d;
      lt_q       <= lt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  logic is_max;
  logic is_min;
  logic kp_d;

  // Decision: ties fail the strict compares, disabled polarity is masked.
  always_comb begin
    is_max = (&gt_q) && hi_q && MAX_EN;
    is_min = (&lt_q) && lo_q && MIN_EN;
    kp_d   = s1_valid_q && (is_max || is_min);
  end

  logic          out_valid_q;
  logic          out_kp_q;
  logic          out_pol_q;
  logic          out_eof_q;
  logic          frame_done_q;
  logic [XW-1:0] out_x_q;
  logic [YW-1:0] out_y_q;

  // Stage 2: output registers; frame_done trails the last result by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_kp_q     <= 1'b0;
      out_pol_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= s1_valid_q;
      out_kp_q     <= kp_d;
      out_pol_q    <= s1_valid_q && is_max;
      out_eof_q    <= s1_valid_q && s1_eof_q;
      out_x_q      <= s1_x_q;
      out_y_q      <= s1_y_q;
      frame_done_q <= out_valid_q && out_eof_q;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_kp     = out_kp_q;
  assign out_pol    = out_pol_q;
  assign out_eof    = out_eof_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign frame_done = frame_done_q;

`ifdef DOG_KPCOUNT_EN
  logic [YW+XW-1:0] kp_count_q;

  // Per-frame keypoint counter: cleared by a start-of-frame beat, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         kp_count_q <= '0;
    else if (sof_beat)                  kp_count_q <= '0;
    else if (kp_d && !(&kp_count_q))    kp_count_q <= kp_count_q + (YW+XW)'(1);
  end

  assign kp_count = kp_count_q;
`endif

endmodule

// File: tb/tb_dog_extrema_stream.sv
// Directed bench for dog_extrema_stream on an 8x6 frame. Four instances share
// the stimulus: [0] MODE=2/THRESH=0, [1] MODE=1, [2] THRESH=100, [3] THRESH=99.
`timescale 1ns/1ps
module tb_dog_extrema_stream;

  localparam int DW = 16;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int XW = 3;
  localparam int YW = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_sof = 1'b0;
  logic signed [DW-1:0] dog0 = '0;
  logic signed [DW-1:0] dog1 = '0;
  logic signed [DW-1:0] dog2 = '0;

  logic [3:0]           ov, okp, opol, oeof, ofd;
  logic [3:0][XW-1:0]   ox;
  logic [3:0][YW-1:0]   oy;
`ifdef DOG_KPCOUNT_EN
  logic [3:0][XW+YW-1:0] okc;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dog_extrema_stream #(
      .DW(DW), .IMG_W(W), .IMG_H(H),
      .MODE((g == 1) ? 1 : 2),
      .THRESH((g == 2) ? 100 : ((g == 3) ? 99 : 0))
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
      .dog0(dog0), .dog1(dog1), .dog2(dog2),
      .out_valid(ov[g]), .out_kp(okp[g]), .out_pol(opol[g]),
      .out_x(ox[g]), .out_y(oy[g]), .out_eof(oeof[g]), .frame_done(ofd[g])
`ifdef DOG_KPCOUNT_EN
      , .kp_count(okc[g])
`endif
    );
  end

  logic signed [DW-1:0] p0 [H][W];
  logic signed [DW-1:0] p1 [H][W];
  logic signed [DW-1:0] p2 [H][W];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int beat43_cyc = 0;
  int sig_ref = 0;

  // Monitor state.
  int n_valid [4];
  int n_kp    [4];
  int kp_x    [4];
  int kp_y    [4];
  int kp_pol  [4];
  int kp_cyc  [4];
  int bad_pol [4];
  int n_eof, eof_x, eof_y, eof_cyc, n_fd, fd_cyc, order_err, ex, ey, sig, kc_fd;

  always @(posedge clk) cyc <= cyc + 1;

  // Sample outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ov[i]) begin
        n_valid[i]++;
        if (okp[i]) begin
          n_kp[i]++;
          kp_x[i]   = int'(ox[i]);
          kp_y[i]   = int'(oy[i]);
          kp_pol[i] = int'(opol[i]);
          kp_cyc[i] = cyc;
        end else if (opol[i]) begin
          bad_pol[i]++;
        end
      end
    end
    if (ov[0]) begin
      if (int'(ox[0]) != ex || int'(oy[0]) != ey) order_err++;
      if (ex == W - 2) begin ex = 1; ey++; end
      else ex++;
      sig = sig * 31 + int'({ox[0], oy[0], okp[0], opol[0]});
    end
    if (oeof[0]) begin
      n_eof++;
      eof_x   = int'(ox[0]);
      eof_y   = int'(oy[0]);
      eof_cyc = cyc;
    end
    if (ofd[0]) begin
      n_fd++;
      fd_cyc = cyc;
`ifdef DOG_KPCOUNT_EN
      kc_fd = int'(okc[0]);
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      n_valid[i] = 0; n_kp[i] = 0; kp_x[i] = -1; kp_y[i] = -1;
      kp_pol[i] = -1; kp_cyc[i] = -1; bad_pol[i] = 0;
    end
    n_eof = 0; eof_x = -1; eof_y = -1; eof_cyc = -1;
    n_fd = 0; fd_cyc = -1; order_err = 0; ex = 1; ey = 1; sig = 0; kc_fd = -1;
  endtask

  task automatic set_all(input int v);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        p0[y][x] = DW'(v); p1[y][x] = DW'(v); p2[y][x] = DW'(v);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int x, input int y, input bit sof);
    in_valid = 1'b1;
    in_sof   = sof;
    dog0 = p0[y][x];
    dog1 = p1[y][x];
    dog2 = p2[y][x];
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (x == 4 && y == 3) beat43_cyc = cyc;
  endtask

  task automatic run_frame(input bit gaps);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        beat(x, y, (x == 0 && y == 0));
      end
    repeat (8) tick();
  endtask

  initial begin
    set_all(0);
    clear_stats();
    repeat (3) tick();
    check("rst_valid", 32'(ov), 0);
    check("rst_kp_pol", 32'({okp, opol}), 0);
    check("rst_eof_fd", 32'({oeof, ofd}), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Constant frame: no keypoints, 24 results in raster order, eof then frame_done.
    set_all(5);
    clear_stats();
    run_frame(1'b0);
    check("const_nvalid", n_valid[0], 24);
    check("const_nkp", n_kp[0], 0);
    check("const_order", order_err, 0);
    check("const_neof", n_eof, 1);
    check("const_eof_xy", eof_x * 16 + eof_y, 6 * 16 + 4);
    check("const_nfd", n_fd, 1);
    check("const_fd_lat", fd_cyc, eof_cyc + 1);
`ifdef DOG_KPCOUNT_EN
    check("const_kpcount", kc_fd, 0);
`endif

    // Positive spike at (3,2): maximum, latency 2 from beat (4,3).
    set_all(0);
    p1[2][3] = 16'sd100;
    clear_stats();
    run_frame(1'b0);
    sig_ref = sig;
    check("max_nvalid", n_valid[0], 24);
    check("max_nkp", n_kp[0], 1);
    check("max_pol", kp_pol[0], 1);
    check("max_xy", kp_x[0] * 16 + kp_y[0], 3 * 16 + 2);
    check("max_latency", kp_cyc[0], beat43_cyc + 2);
    check("max_pol_gated", bad_pol[0], 0);
    check("max_mode1", n_kp[1], 1);
    check("max_thr100", n_kp[2], 0);
    check("max_thr99", n_kp[3], 1);
`ifdef DOG_KPCOUNT_EN
    check("max_kpcount", kc_fd, 1);
`endif

    // Negative spike: minimum with MODE=2, masked with MODE=1.
    p1[2][3] = -16'sd100;
    clear_stats();
    run_frame(1'b0);
    check("min_nkp", n_kp[0], 1);
    check("min_pol", kp_pol[0], 0);
    check("min_xy", kp_x[0] * 16 + kp_y[0], 3 * 16 + 2);
    check("min_mode1", n_kp[1], 0);
    check("min_thr100", n_kp[2], 0);
    check("min_thr99", n_kp[3], 1);

    // Tie with a lower-plane neighbour at (2,1): not an extremum.
    p1[2][3] = 16'sd100;
    p0[1][2] = 16'sd100;
    clear_stats();
    run_frame(1'b0);
    check("tie_nkp", n_kp[0], 0);
    check("tie_nvalid", n_valid[0], 24);

    // Same spike with random input gaps: identical result stream.
    set_all(0);
    p1[2][3] = 16'sd100;
    clear_stats();
    run_frame(1'b1);
    check("gap_nvalid", n_valid[0], 24);
    check("gap_signature", sig, sig_ref);
    check("gap_xy", kp_x[0] * 16 + kp_y[0], 3 * 16 + 2);

    // Spikes on the border (x=0, y=5, y=0) never yield a keypoint.
    set_all(0);
    p1[3][0] = 16'sd100;
    p1[5][2] = 16'sd100;
    p1[0][4] = 16'sd100;
    clear_stats();
    run_frame(1'b0);
    check("border_nkp", n_kp[0], 0);
    check("border_nvalid", n_valid[0], 24);

    // Resync: sof replaces beat (5,3); 9 partial results then a full frame.
    set_all(0);
    clear_stats();
    for (int i = 0; i < 3 * W + 5; i++) beat(i % W, i / W, (i == 0));
    run_frame(1'b0);
    check("resync_nvalid", n_valid[0], 9 + 24);
    check("resync_neof", n_eof, 1);
    check("resync_eof_xy", eof_x * 16 + eof_y, 6 * 16 + 4);
    check("resync_nfd", n_fd, 1);

    // Reset mid-frame while results are streaming.
    clear_stats();
    for (int i = 0; i < 2 * W + 5; i++) beat(i % W, i / W, (i == 0));
    check("prerst_valid", 32'(ov[0]), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'({ov[0], okp[0], opol[0], oeof[0], ofd[0]}), 0);
    check("midrst_xy", 32'({ox[0], oy[0]}), 0);
    tick();
    rst_n = 1'b1;
    tick();
    clear_stats();
    for (int i = 0; i < 30; i++) beat(i % W, (i / W) % H, 1'b0);
    repeat (6) tick();
    check("nosof_nvalid", n_valid[0], 0);
    clear_stats();
    run_frame(1'b0);
    check("postrst_nvalid", n_valid[0], 24);
    check("postrst_nfd", n_fd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dog_extrema_stream.md
Name: dog_extrema_stream

Overview:
- Streaming 3x3x3 scale-space extremum detector for the SIFT-style keypoint path.
- Consumes three adjacent DoG planes in raster order, one pixel per beat.
- Holds two lines per plane, not whole frames.
- Tests the middle-plane centre against all 26 neighbours and emits one keypoint flag per interior pixel, with coordinates and polarity, to the descriptor/NMS stage.

Parameters:
- DW, 16: signed DoG sample width.
- IMG_W, 320: pixels per line (>=3).
- IMG_H, 480: lines per frame (>=3).
- MODE, 2: 0 = minima only, 1 = maxima only, 2 = both.
- THRESH, 0: unsigned contrast threshold, DW-1 bits.
- XW, $clog2(IMG_W): x coordinate width.
- YW, $clog2(IMG_H): y coordinate width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat qualifier; gaps allowed; no backpressure
- in_sof  in  1  marks pixel (0,0); sampled only with in_valid
- dog0  in  DW  signed, lower scale
- dog1  in  DW  signed, centre scale
- dog2  in  DW  signed, upper scale
- out_valid  out  1  result qualifier, one pulse per interior pixel
- out_kp  out  1  centre is an extremum
- out_pol  out  1  1 = maximum, 0 = minimum; 0 when out_kp = 0
- out_x  out  XW  centre column
- out_y  out  YW  centre row
- out_eof  out  1  with out_valid on the last interior result (IMG_W-2, IMG_H-2)
- frame_done  out  1  one-cycle pulse, cycle after out_eof

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs 0; FSM in IDLE; counters 0.
- Line-buffer RAM contents are not cleared; they are don't-care, because results are gated by counters.

FSM:
- IDLE: beats ignored until in_valid & in_sof. That beat is pixel (0,0) and is processed; go to ACTIVE.
- ACTIVE: each in_valid beat advances x. At x = IMG_W-1, x wraps to 0 and y increments.
- Beat (IMG_W-1, IMG_H-1) is processed, then FSM goes to DONE.
- DONE: one cycle; frame_done is generated from the pipelined eof; return to IDLE.
- in_sof with in_valid while ACTIVE resynchronises: the beat is treated as (0,0), x/y restart, and in-flight results already in the pipeline still complete. No partial-frame eof is issued.

Datapath:
- Per plane, two line buffers of IMG_W x DW.
  - On each beat, read column x of row y-1 and y-2, then write the new sample / shifted line.
  - Read-during-write at the same address returns old data.
- Per plane, a 3x3 window shift register advances only on accepted beats.

Pipeline (fixed, independent of input gaps):
- Beat at edge T with x>=2, y>=2: the window holds columns x-2..x, rows y-2..y. Centre is (x-1, y-1).
- Edge T+1: 26 strict signed compares are registered.
- Edge T+2: out_* registered. out_valid is high for exactly the cycle after edge T+2 (latency 2).
- Beats with x<2 or y<2 produce no output. Total outputs per frame = (IMG_W-2)*(IMG_H-2).

Decision rules (c = centre of dog1):
- max = c > all 26 neighbours and c > +THRESH.
- min = c < all 26 neighbours and c < -THRESH.
- Ties are never extrema. MODE masks the disabled polarity.
- out_kp = max | min; out_pol = max.
- Compares are sign-extended to DW+1 bits; no overflow possible.

Optional Feature:
Macro DOG_KPCOUNT_EN.
- Defined: adds output kp_count [YW+XW] (reset 0).
  - Counts out_kp pulses in the current frame; saturates at all-ones.
  - Value valid while frame_done is high; clears on the next in_sof beat.
- Undefined: port and counter absent. All other behaviour is identical.

Decomposition:
- Package dog_pkg:
  - MODE encodings (MODE_MIN, MODE_MAX, MODE_BOTH).
  - FSM state enum (IDLE, ACTIVE, DONE).
  - Function for signed DW+1 compare.
- Sub-module dog_linebuf: one plane's two-line buffer plus 3x3 window, parameterised by DW and IMG_W. Instantiated three times.
- The top holds the counters, FSM, compare tree and output registers.

Test Plan:
Bench uses IMG_W=8, IMG_H=6.
1. Constant frame (all planes 5) -> 24 out_valid pulses, all out_kp=0; out_eof on (6,4); frame_done one cycle later.
2. dog1(3,2)=100, all else 0, MODE=2 -> single out_kp=1, pol=1, x=3, y=2, two cycles after beat (4,3).
3. dog1(3,2)=-100, MODE=1 -> out_kp=0; with MODE=2 -> out_kp=1, pol=0.
4. Case 2 with dog0(2,1)=100 (tie) -> out_kp=0. With THRESH=100 and no tie -> out_kp=0; with THRESH=99 -> out_kp=1.
5. Random in_valid gaps (~50% duty) on case 2 -> identical result sequence. Spike at x=0 or y=5 -> no keypoint.
6. in_sof asserted at beat (5,3) of a frame -> restart from (0,0); next full frame yields 24 results. rst_n pulsed mid-frame -> outputs 0 immediately; no output until a new in_sof.
